// File: rtl/fpu_div_iterative_if.sv
// Operand/result handshake bundle between FPU decode, the iterative divider and rounding.
interface fpu_div_iterative_if;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned SIG_W  = 24;

  logic              in_valid;
  logic              in_ready;
  logic              a_sign;
  logic              b_sign;
  logic [EXP_W-1:0]  a_exponent;
  logic [EXP_W-1:0]  b_exponent;
  logic [FRAC_W-1:0] a_mantissa;
  logic [FRAC_W-1:0] b_mantissa;
  logic              a_nan;
  logic              a_inf;
  logic              a_zero;
  logic              a_norm;
  logic              b_nan;
  logic              b_inf;
  logic              b_zero;
  logic              b_norm;
  logic [2:0]        mode;

  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [SIG_W-1:0]  out_mantissa;
  logic [EXP_W-1:0]  out_exponent;
  logic [2:0]        out_guard;
  logic              out_nan;
  logic              out_inf;
  logic              out_zero;
  logic [2:0]        out_mode;

  modport master (
    output in_valid, a_sign, b_sign, a_exponent, b_exponent, a_mantissa, b_mantissa,
           a_nan, a_inf, a_zero, a_norm, b_nan, b_inf, b_zero, b_norm, mode, out_ready,
    input  in_ready, out_valid, out_sign, out_mantissa, out_exponent, out_guard,
           out_nan, out_inf, out_zero, out_mode
  );

  modport slave (
    input  in_valid, a_sign, b_sign, a_exponent, b_exponent, a_mantissa, b_mantissa,
           a_nan, a_inf, a_zero, a_norm, b_nan, b_inf, b_zero, b_norm, mode, out_ready,
    output in_ready, out_valid, out_sign, out_mantissa, out_exponent, out_guard,
           out_nan, out_inf, out_zero, out_mode
  );
endinterface

// File: rtl/fpu_div_iterative.sv
// Radix-2 restoring single-precision divider; emits an unrounded normalized result
// (24-bit significand, 3 guard bits, class flags) for the shared rounding stage.
module fpu_div_iterative #(
  parameter int unsigned ITERATIONS = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  fpu_div_iterative_if.slave  bus
);

  localparam int unsigned SIG_W = 24;
  localparam int unsigned REM_W = 25;
  localparam int unsigned E_W   = 10;
  localparam int unsigned XP_W  = 8;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt_q, cnt_nxt;
  logic [ITERATIONS-1:0]   q_q, q_nxt;
  logic [REM_W-1:0]        r_q, r_nxt;
  logic [SIG_W-1:0]        sig_b_q, sig_b_nxt;
  logic signed [E_W-1:0]   e_q, e_nxt;

  logic                    in_ready_q, in_ready_nxt;
  logic                    out_valid_q, out_valid_nxt;
  logic                    out_sign_q, out_sign_nxt;
  logic [SIG_W-1:0]        out_mantissa_q, out_mantissa_nxt;
  logic [XP_W-1:0]         out_exponent_q, out_exponent_nxt;
  logic [2:0]              out_guard_q, out_guard_nxt;
  logic                    out_nan_q, out_nan_nxt;
  logic                    out_inf_q, out_inf_nxt;
  logic                    out_zero_q, out_zero_nxt;
  logic [2:0]              out_mode_q, out_mode_nxt;

  // Denormals flush to zero; nan/inf encodings keep their own class.
  logic a_z, b_z, spec_nan, spec_inf, spec_zero;
  assign a_z = bus.a_zero | (~bus.a_norm & ~bus.a_nan & ~bus.a_inf);
  assign b_z = bus.b_zero | (~bus.b_norm & ~bus.b_nan & ~bus.b_inf);
  assign spec_nan  = bus.a_nan | bus.b_nan | (a_z & b_z) | (bus.a_inf & bus.b_inf);
  assign spec_inf  = bus.a_inf | b_z;
  assign spec_zero = a_z | bus.b_inf;

  logic signed [E_W-1:0] e_init;
  assign e_init = $signed(E_W'(bus.a_exponent) - E_W'(bus.b_exponent) + E_W'(127));

  // One restoring step: compare, conditionally subtract, then shift.
  logic             r_ge;
  logic [REM_W-1:0] r_sel;
  assign r_ge  = r_q >= REM_W'(sig_b_q);
  assign r_sel = r_ge ? (r_q - REM_W'(sig_b_q)) : r_q;

  logic                  sticky, rem_nz;
  logic signed [E_W-1:0] e_adj;
  assign rem_nz = (r_q != '0);
  assign sticky = q_q[0] | rem_nz;
  assign e_adj  = q_q[ITERATIONS-1] ? e_q : (e_q - 10'sd1);

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt_q;
    q_nxt            = q_q;
    r_nxt            = r_q;
    sig_b_nxt        = sig_b_q;
    e_nxt            = e_q;
    out_valid_nxt    = out_valid_q;
    out_sign_nxt     = out_sign_q;
    out_mantissa_nxt = out_mantissa_q;
    out_exponent_nxt = out_exponent_q;
    out_guard_nxt    = out_guard_q;
    out_nan_nxt      = out_nan_q;
    out_inf_nxt      = out_inf_q;
    out_zero_nxt     = out_zero_q;
    out_mode_nxt     = out_mode_q;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sig_b_nxt    = {1'b1, bus.b_mantissa};
          r_nxt        = REM_W'({1'b1, bus.a_mantissa});
          q_nxt        = '0;
          cnt_nxt      = '0;
          e_nxt        = e_init;
          out_sign_nxt = bus.a_sign ^ bus.b_sign;
          out_mode_nxt = bus.mode;
          if (spec_nan | spec_inf | spec_zero) begin
            state_nxt        = DONE;
            out_nan_nxt      = spec_nan;
            out_inf_nxt      = ~spec_nan & spec_inf;
            out_zero_nxt     = ~spec_nan & ~spec_inf & spec_zero;
            out_mantissa_nxt = '0;
            out_exponent_nxt = '0;
            out_guard_nxt    = '0;
          end else begin
            state_nxt = DIVIDE;
          end
        end
      end

      DIVIDE: begin
        q_nxt   = ITERATIONS'({q_q, r_ge});
        r_nxt   = REM_W'({r_sel, 1'b0});
        cnt_nxt = cnt_q + 5'd1;
        if (cnt_q == CNT_W'(ITERATIONS - 1)) state_nxt = NORM;
      end

      NORM: begin
        state_nxt        = DONE;
        out_nan_nxt      = 1'b0;
        out_inf_nxt      = 1'b0;
        out_zero_nxt     = 1'b0;
        out_mantissa_nxt = '0;
        out_exponent_nxt = '0;
        out_guard_nxt    = '0;
        if (e_adj >= 10'sd255) begin
          out_inf_nxt = 1'b1;
        end else if (e_adj <= 10'sd0) begin
          out_zero_nxt = 1'b1;
        end else begin
          out_exponent_nxt = e_adj[XP_W-1:0];
          if (q_q[ITERATIONS-1]) begin
            out_mantissa_nxt = q_q[ITERATIONS-1 -: SIG_W];
            out_guard_nxt    = {q_q[2], q_q[1], sticky};
          end else begin
            out_mantissa_nxt = q_q[ITERATIONS-2 -: SIG_W];
            out_guard_nxt    = {q_q[1], q_q[0], rem_nz};
          end
        end
      end

      DONE: begin
        // First DONE cycle raises valid; the handshake then returns to IDLE.
        if (!out_valid_q) begin
          out_valid_nxt = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    in_ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt_q          <= '0;
      q_q            <= '0;
      r_q            <= '0;
      sig_b_q        <= '0;
      e_q            <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_sign_q     <= 1'b0;
      out_mantissa_q <= '0;
      out_exponent_q <= '0;
      out_guard_q    <= '0;
      out_nan_q      <= 1'b0;
      out_inf_q      <= 1'b0;
      out_zero_q     <= 1'b0;
      out_mode_q     <= '0;
    end else begin
      state          <= state_nxt;
      cnt_q          <= cnt_nxt;
      q_q            <= q_nxt;
      r_q            <= r_nxt;
      sig_b_q        <= sig_b_nxt;
      e_q            <= e_nxt;
      in_ready_q     <= in_ready_nxt;
      out_valid_q    <= out_valid_nxt;
      out_sign_q     <= out_sign_nxt;
      out_mantissa_q <= out_mantissa_nxt;
      out_exponent_q <= out_exponent_nxt;
      out_guard_q    <= out_guard_nxt;
      out_nan_q      <= out_nan_nxt;
      out_inf_q      <= out_inf_nxt;
      out_zero_q     <= out_zero_nxt;
      out_mode_q     <= out_mode_nxt;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sign     = out_sign_q;
  assign bus.out_mantissa = out_mantissa_q;
  assign bus.out_exponent = out_exponent_q;
  assign bus.out_guard    = out_guard_q;
  assign bus.out_nan      = out_nan_q;
  assign bus.out_inf      = out_inf_q;
  assign bus.out_zero     = out_zero_q;
  assign bus.out_mode     = out_mode_q;

endmodule
